// File: rtl/zacore_fetch.sv
// Zacore fetch stage: PC generation, in-order imem requests with credit-limited
// outstanding count, response buffering and a registered beat to decode.
package zacore_pkg;
  typedef logic [30:0] pc_t;
  typedef struct packed { logic valid; pc_t pc; } redirect_info_t;
  typedef struct packed { redirect_info_t datapath_info; } execute_fetch_if_t;
  typedef struct packed { logic valid; pc_t pc; logic [31:0] inst; } decode_info_t;
  typedef struct packed { decode_info_t datapath_info; } fetch_decode_if_t;
endpackage

module zacore_fetch
  import zacore_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              o_imem_req_valid,
  input  logic              i_imem_req_ready,
  output pc_t               o_imem_req_addr,
  input  logic              i_imem_rsp_valid,
  input  logic [31:0]       i_imem_rsp_data,
  input  execute_fetch_if_t i_execute_fetch,
  input  logic              i_decode_stall,
  output fetch_decode_if_t  o_fetch_decode
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);
  typedef logic [CW-1:0] cnt_t;
  typedef logic [PW-1:0] ptr_t;

  function automatic ptr_t inc(input ptr_t p);
    return (p == ptr_t'(DEPTH - 1)) ? '0 : ptr_t'(p + ptr_t'(1));
  endfunction

  pc_t              r_pc;
  cnt_t             r_outstanding, r_discard, r_count;
  ptr_t             r_tag_wp, r_tag_rp, r_wp, r_rp;
  pc_t              r_tag   [DEPTH];
  pc_t              r_fq_pc [DEPTH];
  logic [31:0]      r_fq_ins[DEPTH];
  fetch_decode_if_t r_fd;

  logic        w_redirect, w_req_fire, w_push, w_pop;
  logic [CW:0] w_credit;

  assign w_redirect = i_execute_fetch.datapath_info.valid;
  assign w_credit   = {1'b0, r_outstanding} + {1'b0, r_count};
  // Gated by rst_n so no request leaks out while reset is held.
  assign o_imem_req_valid = rst_n && !w_redirect && (w_credit < (CW+1)'(DEPTH));
  assign o_imem_req_addr  = r_pc;
  assign w_req_fire = o_imem_req_valid && i_imem_req_ready;
  assign w_push     = i_imem_rsp_valid && (r_discard == '0) && !w_redirect;
  assign w_pop      = !w_redirect && !i_decode_stall && (r_count != '0);
  assign o_fetch_decode = r_fd;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc          <= RESET_PC[31:1];
      r_outstanding <= '0;
      r_discard     <= '0;
      r_tag_wp      <= '0;
      r_tag_rp      <= '0;
    end else begin
      r_outstanding <= r_outstanding + cnt_t'(w_req_fire) - cnt_t'(i_imem_rsp_valid);
      if (w_req_fire) r_tag_wp <= inc(r_tag_wp);
      if (i_imem_rsp_valid) r_tag_rp <= inc(r_tag_rp);
      if (w_redirect) begin
        r_pc      <= i_execute_fetch.datapath_info.pc;
        r_discard <= r_outstanding - cnt_t'(i_imem_rsp_valid);
      end else begin
        if (w_req_fire) r_pc <= r_pc + pc_t'(2);
        if (i_imem_rsp_valid && r_discard != '0) r_discard <= r_discard - cnt_t'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wp    <= '0;
      r_rp    <= '0;
      r_count <= '0;
    end else if (w_redirect) begin
      r_wp    <= '0;
      r_rp    <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wp <= inc(r_wp);
      if (w_pop)  r_rp <= inc(r_rp);
      r_count <= r_count + cnt_t'(w_push) - cnt_t'(w_pop);
    end
  end

  // Storage needs no reset; pointers and counts qualify every read.
  always_ff @(posedge clk) begin
    if (w_req_fire) r_tag[r_tag_wp] <= r_pc;
    if (w_push) begin
      r_fq_pc[r_wp]  <= r_tag[r_tag_rp];
      r_fq_ins[r_wp] <= i_imem_rsp_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fd <= '0;
    end else if (w_redirect) begin
      r_fd.datapath_info.valid <= 1'b0;
    end else if (!i_decode_stall) begin
      r_fd.datapath_info.valid <= (r_count != '0);
      if (r_count != '0) begin
        r_fd.datapath_info.pc   <= r_fq_pc[r_rp];
        r_fd.datapath_info.inst <= r_fq_ins[r_rp];
      end
    end
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(w_push && !w_pop && r_count == cnt_t'(DEPTH)));
endmodule

// File: tb/tb_zacore_fetch.sv
// Bench for zacore_fetch: directed scenarios plus randomized ready/latency/stall/redirect
// traffic, checked against a sequential-pc reference and an in-order memory model.
module tb_zacore_fetch;
  import zacore_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  logic req_valid, ready, rsp_valid, stall;
  pc_t  req_addr;
  logic [31:0] rsp_data;
  execute_fetch_if_t ef;
  fetch_decode_if_t  fd;

  always #5 clk = ~clk;

  zacore_fetch #(.RESET_PC(32'h0000_0100), .DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .o_imem_req_valid(req_valid), .i_imem_req_ready(ready), .o_imem_req_addr(req_addr),
    .i_imem_rsp_valid(rsp_valid), .i_imem_rsp_data(rsp_data),
    .i_execute_fetch(ef), .i_decode_stall(stall), .o_fetch_decode(fd)
  );

  typedef struct { int due; pc_t addr; } mreq_t;
  mreq_t memq[$];

  int   vecs = 0, errs = 0, cyc = 0, last_due = -1, nbeats = 0, b0;
  int   lat_lo = 1, lat_hi = 1;
  pc_t  exp_req_pc, exp_dec_pc, held_addr;
  logic prev_hold, prev_wait, prev_redir;
  fetch_decode_if_t held_fd;

  function automatic logic [31:0] word_of(input pc_t p);
    return {p, 1'b1} ^ 32'h5A5A_C3C3;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: got %h, want %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    memq.delete();
    last_due = -1; cyc = 0;
    exp_req_pc = 31'h80; exp_dec_pc = 31'h80;
    prev_hold = 0; prev_wait = 0; prev_redir = 0;
  endtask

  // One clock: check outputs mid-cycle, update the model, then drive the memory response.
  task automatic step();
    int d;
    @(negedge clk);
    if (prev_redir) chk("redir_clears_beat", fd.datapath_info.valid, 1'b0);
    if (prev_hold) chk("hold_beat", fd, held_fd);
    else if (fd.datapath_info.valid) begin
      chk("beat_pc", fd.datapath_info.pc, exp_dec_pc);
      chk("beat_inst", fd.datapath_info.inst, word_of(exp_dec_pc));
      exp_dec_pc = exp_dec_pc + 31'd2;
      nbeats++;
    end
    if (prev_wait && !ef.datapath_info.valid) begin
      chk("req_hold_valid", req_valid, 1'b1);
      chk("req_hold_addr", req_addr, held_addr);
    end
    if (ef.datapath_info.valid) chk("no_req_in_redirect", req_valid, 1'b0);
    if (req_valid && ready) begin
      chk("req_addr", req_addr, exp_req_pc);
      exp_req_pc = exp_req_pc + 31'd2;
      d = cyc + int'($urandom_range(lat_hi, lat_lo));
      if (d <= last_due) d = last_due + 1;
      last_due = d;
      memq.push_back('{due: d, addr: req_addr});
    end
    prev_wait  = req_valid && !ready;
    held_addr  = req_addr;
    prev_hold  = stall && !ef.datapath_info.valid;
    held_fd    = fd;
    prev_redir = ef.datapath_info.valid;
    if (ef.datapath_info.valid) begin
      exp_dec_pc = ef.datapath_info.pc;
      exp_req_pc = ef.datapath_info.pc;
    end
    @(posedge clk);
    #1;
    cyc++;
    if (memq.size() != 0 && memq[0].due <= cyc) begin
      rsp_valid = 1'b1;
      rsp_data  = word_of(memq[0].addr);
      void'(memq.pop_front());
    end else begin
      rsp_valid = 1'b0;
      rsp_data  = '0;
    end
  endtask

  task automatic redirect_to(input pc_t t);
    ef = '0;
    ef.datapath_info.valid = 1'b1;
    ef.datapath_info.pc    = t;
  endtask

  initial begin
    rst_n = 0; ready = 0; stall = 0; ef = '0; rsp_valid = 0; rsp_data = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req_valid", req_valid, 1'b0);
    chk("rst_fd", fd, 64'h0);
    chk("rst_addr", req_addr, 31'h80);

    // Streaming, latency 1, no stall.
    rst_n = 1; ready = 1;
    #1;
    chk("first_req_valid", req_valid, 1'b1);
    chk("first_req_addr", req_addr, 31'h80);
    repeat (3) step();
    #1;
    chk("first_beat_valid", fd.datapath_info.valid, 1'b1);
    chk("first_beat_pc", fd.datapath_info.pc, 31'h80);
    b0 = nbeats;
    repeat (10) step();
    chk("no_gaps", nbeats - b0, 10);

    // Decode stall for 6 cycles: credit must throttle issue.
    stall = 1;
    repeat (5) step();
    #1;
    chk("stall_credit_stop", req_valid, 1'b0);
    step();
    stall = 0;
    repeat (10) step();

    // Redirect with two outstanding and a response in the redirect cycle.
    lat_lo = 2; lat_hi = 2;
    repeat (8) step();
    redirect_to(31'h400);
    step();
    ef = '0;
    #1;
    chk("redir_req_valid", req_valid, 1'b1);
    chk("redir_req_addr", req_addr, 31'h400);
    for (int k = 0; k < 3; k++) begin
      step();
      #1;
      chk("redir_bubble", fd.datapath_info.valid, 1'b0);
    end
    step();
    #1;
    chk("redir_first_valid", fd.datapath_info.valid, 1'b1);
    chk("redir_first_pc", fd.datapath_info.pc, 31'h400);
    lat_lo = 1; lat_hi = 1;
    repeat (6) step();

    // Redirect while decode is stalled on a valid beat.
    stall = 1;
    step();
    #1;
    chk("stalled_beat_valid", fd.datapath_info.valid, 1'b1);
    redirect_to(31'h300);
    step();
    ef = '0;
    #1;
    chk("stall_redir_clear", fd.datapath_info.valid, 1'b0);
    stall = 0;
    repeat (8) step();

    // Program counter wrap.
    redirect_to(31'h7FFF_FFFE);
    step();
    ef = '0;
    #1;
    chk("wrap_addr_top", req_addr, 31'h7FFF_FFFE);
    step();
    #1;
    chk("wrap_addr_zero", req_addr, 31'h0);
    repeat (10) step();

    // Randomized ready, latency, stall and redirect traffic.
    lat_lo = 1; lat_hi = 3;
    for (int i = 0; i < 800; i++) begin
      ready = ($urandom_range(3, 0) != 0);
      stall = ($urandom_range(3, 0) == 0);
      ef = '0;
      if ($urandom_range(39, 0) == 0) redirect_to(pc_t'($urandom));
      step();
    end
    ef = '0; stall = 0; ready = 1;
    repeat (5) step();

    // Asynchronous reset mid-burst.
    #2;
    rst_n = 0;
    #1;
    chk("midrst_req_valid", req_valid, 1'b0);
    chk("midrst_fd", fd, 64'h0);
    chk("midrst_addr", req_addr, 31'h80);
    model_reset();
    rsp_valid = 0; rsp_data = '0;
    @(posedge clk);
    #1;
    rst_n = 1;
    #1;
    chk("postrst_req_addr", req_addr, 31'h80);
    b0 = nbeats;
    repeat (20) step();
    chk("postrst_beats", nbeats - b0 > 10, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
